axi_refill_arbiter: RTL

Refill controller and arbiter that sits between two line caches (e.g. I-side and D-side) and one AXI4 read-only master port. It watches each cache's `miss` level, grants one requester at a time round-robin, and issues a single line-aligned INCR burst. Returned R beats are steered into the granted cache's refill port (`mem_addr`/`mem_data_in`/`mem_wstb`/`mem_data_valid`/`mem_last`).

---
 rtl/cache_pkg.sv | 23 ++
 rtl/axi_refill_arbiter_rr_arb2.sv | 15 +
 rtl/axi_refill_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache/refill definitions: AXI encodings, refill FSM states and
// line-geometry helpers used by the refill arbiter.
package cache_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } refill_state_e;

    // Number of data beats needed to move one cache line.
    function automatic int beats_per_line(input int line_size_bits, input int data_width);
        return (1 << line_size_bits) / (data_width / 8);
    endfunction

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_refill_arbiter_rr_arb2.sv
// Two-requester round-robin pick; the previous winner is held by the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        gnt = req[1];
        if (req == 2'b11) begin
            gnt = ~last;
        end
    end

endmodule

// File: rtl/axi_refill_arbiter.sv
// Line refill controller: arbitrates two cache misses onto one AXI4 read
// port and steers the returning beats into the granted cache.
module axi_refill_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_SIZE_BITS = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic [1:0]              req_miss,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,

    output logic [ADDR_WIDTH-1:0]   fill_addr,
    output logic [DATA_WIDTH-1:0]   fill_data,
    output logic [DATA_WIDTH/8-1:0] fill_wstb,
    output logic [1:0]              fill_valid,
    output logic                    fill_last,

    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,

    output logic                    bus_err,
    output logic                    proto_err
);

    localparam int BEATS      = beats_per_line(LINE_SIZE_BITS, DATA_WIDTH);
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~ADDR_WIDTH'((64'd1 << LINE_SIZE_BITS) - 64'd1);

    refill_state_e          state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  line_base_q, line_base_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                   bus_err_q, bus_err_d;
    logic                   proto_err_q, proto_err_d;
    logic                   arb_gnt;
    logic                   at_last_beat;

    rr_arb2 u_rr_arb2 (
        .req  (req_miss),
        .last (last_grant_q),
        .gnt  (arb_gnt)
    );

    // NOTE: reset is sampled on the clock edge only; every register here,
    // including the error flags, returns to its reset value on that edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            line_base_q  <= '0;
            beat_cnt_q   <= '0;
            bus_err_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            line_base_q  <= line_base_d;
            beat_cnt_q   <= beat_cnt_d;
            bus_err_q    <= bus_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign at_last_beat = (beat_cnt_q == LAST_BEAT);

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        line_base_d   = line_base_q;
        beat_cnt_d    = beat_cnt_q;
        bus_err_d     = bus_err_q;
        proto_err_d   = proto_err_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        fill_valid    = 2'b00;
        fill_last     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_miss) begin
                    grant_d      = arb_gnt;
                    last_grant_d = arb_gnt;
                    line_base_d  = (arb_gnt ? req1_addr : req0_addr) & LINE_MASK;
                    beat_cnt_d   = '0;
                    state_d      = ST_ADDR;
                end
            end

            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                m_axi_rready        = 1'b1;
                fill_valid[grant_q] = m_axi_rvalid;
                fill_last           = m_axi_rvalid & m_axi_rlast;
                if (m_axi_rvalid) begin
                    // Count wraps inside the line; rlast alone ends the burst.
                    beat_cnt_d = at_last_beat ? '0 : beat_cnt_q + CNT_W'(1);
                    if (m_axi_rresp != AXI_RESP_OKAY) begin
                        bus_err_d = 1'b1;
                    end
                    if (m_axi_rlast != at_last_beat) begin
                        proto_err_d = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign m_axi_araddr  = line_base_q;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = axi_size(DATA_WIDTH);
    assign m_axi_arburst = AXI_BURST_INCR;

    assign fill_addr = line_base_q + (ADDR_WIDTH'(beat_cnt_q) << BYTE_SHIFT);
    assign fill_data = m_axi_rdata;
    assign fill_wstb = '1;

    assign bus_err   = bus_err_q;
    assign proto_err = proto_err_q;

endmodule
